// File: rtl/pong_pkg.sv
// Shared constants for the pong datapath: default screen size, direction and FSM encodings.
// The direction encodings must stay identical to the direction-control stage.
package pong_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_V_ACTIVE = 480;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

  // Shared by both axes: LEFT and UP both move towards coordinate 0.
  localparam logic DIR_DEC   = 1'b1;

  localparam logic ST_SERVE  = 1'b0;
  localparam logic ST_MOVE   = 1'b1;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_stepper.sv
// Next-position logic for one ball axis: saturating step towards 0 or LIMIT, or reload
// of the centre coordinate. Purely combinational.
module axis_stepper
  import pong_pkg::*;
#(
  parameter int unsigned LIMIT = 632,
  parameter int unsigned STEP  = 2,
  parameter int unsigned CTR   = 316
) (
  input  logic [9:0] i_Pos,
  input  logic       i_Dir,
  input  logic       i_Step_En,
  input  logic       i_Load_Ctr,
  output logic [9:0] o_Pos_Next
);

  localparam logic [10:0] STEP_W  = 11'(STEP);
  localparam logic [10:0] LIMIT_W = 11'(LIMIT);
  localparam logic [10:0] INC_THR = 11'(LIMIT - STEP);

  logic [10:0] w_pos;
  logic [10:0] w_dec;
  logic [10:0] w_inc;
  logic [10:0] w_res;

  // 11-bit arithmetic so neither direction can wrap before the clamp is applied.
  always_comb begin
    w_pos = {1'b0, i_Pos};
    w_dec = (w_pos < STEP_W) ? 11'd0 : (w_pos - STEP_W);
    w_inc = (w_pos > INC_THR) ? LIMIT_W : (w_pos + STEP_W);
    w_res = w_pos;
    if (i_Load_Ctr) begin
      w_res = 11'(CTR);
    end else if (i_Step_En) begin
      w_res = (i_Dir == DIR_DEC) ? w_dec : w_inc;
    end
  end

  assign o_Pos_Next = 10'(w_res);

endmodule

// File: rtl/ball_motion.sv
// Ball position owner: serve hold, per-frame saturating movement, edge flags and the
// registered pixel-compare strobes used by the pixel mux and the direction-control stage.
module ball_motion
  import pong_pkg::*;
#(
  parameter int unsigned H_ACTIVE        = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE        = DEF_V_ACTIVE,
  parameter int unsigned BALL_SIZE       = 8,
  parameter int unsigned STEP            = 2,
  parameter int unsigned FRAMES_PER_STEP = 1,
  parameter int unsigned SERVE_FRAMES    = 60
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Frame_Tick,
  input  logic       i_Recenter,
  input  logic       i_HDir,
  input  logic       i_VDir,
  input  logic [9:0] i_Col,
  input  logic [9:0] i_Row,
  output logic [9:0] o_Ball_X,
  output logic [9:0] o_Ball_Y,
  output logic       o_Draw_Ball,
  output logic       o_VBall,
  output logic       o_At_Left,
  output logic       o_At_Right,
  output logic       o_At_Top,
  output logic       o_At_Bottom,
  output logic       o_Serving
);

  localparam int unsigned X_MAX = H_ACTIVE - BALL_SIZE;
  localparam int unsigned Y_MAX = V_ACTIVE - BALL_SIZE;
  localparam int unsigned X_CTR = X_MAX / 2;
  localparam int unsigned Y_CTR = Y_MAX / 2;
  localparam int unsigned SRV_W = cnt_width(SERVE_FRAMES);
  localparam int unsigned DIV_W = cnt_width(FRAMES_PER_STEP);

  localparam logic [SRV_W-1:0] SRV_LAST = SRV_W'(SERVE_FRAMES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAMES_PER_STEP - 1);
  localparam logic [10:0]      SIZE_W   = 11'(BALL_SIZE);

  logic             r_state;
  logic [SRV_W-1:0] r_srv_cnt;
  logic [DIV_W-1:0] r_div_cnt;
  logic [9:0]       r_ball_x;
  logic [9:0]       r_ball_y;
  logic             r_vball;
  logic             r_draw;

  logic             w_state_nxt;
  logic [SRV_W-1:0] w_srv_nxt;
  logic [DIV_W-1:0] w_div_nxt;
  logic             w_step_en;
  logic             w_load_ctr;
  logic [9:0]       w_x_nxt;
  logic [9:0]       w_y_nxt;

  // Recenter wins over a coincident tick, so that tick neither steps nor counts.
  always_comb begin
    w_state_nxt = r_state;
    w_srv_nxt   = r_srv_cnt;
    w_div_nxt   = r_div_cnt;
    w_step_en   = 1'b0;
    w_load_ctr  = 1'b0;
    if (i_Recenter) begin
      w_load_ctr  = 1'b1;
      w_state_nxt = ST_SERVE;
      w_srv_nxt   = '0;
      w_div_nxt   = '0;
    end else if (i_Frame_Tick) begin
      if (r_state == ST_SERVE) begin
        if (r_srv_cnt == SRV_LAST) begin
          w_state_nxt = ST_MOVE;
          w_srv_nxt   = '0;
        end else begin
          w_srv_nxt = r_srv_cnt + SRV_W'(1);
        end
      end else begin
        if (r_div_cnt == DIV_LAST) begin
          w_div_nxt = '0;
          w_step_en = 1'b1;
        end else begin
          w_div_nxt = r_div_cnt + DIV_W'(1);
        end
      end
    end
  end

  axis_stepper #(
    .LIMIT (X_MAX),
    .STEP  (STEP),
    .CTR   (X_CTR)
  ) u_step_x (
    .i_Pos      (r_ball_x),
    .i_Dir      (i_HDir),
    .i_Step_En  (w_step_en),
    .i_Load_Ctr (w_load_ctr),
    .o_Pos_Next (w_x_nxt)
  );

  axis_stepper #(
    .LIMIT (Y_MAX),
    .STEP  (STEP),
    .CTR   (Y_CTR)
  ) u_step_y (
    .i_Pos      (r_ball_y),
    .i_Dir      (i_VDir),
    .i_Step_En  (w_step_en),
    .i_Load_Ctr (w_load_ctr),
    .o_Pos_Next (w_y_nxt)
  );

  logic [10:0] w_col;
  logic [10:0] w_row;
  logic [10:0] w_x;
  logic [10:0] w_y;
  logic        w_vball;
  logic        w_hball;

  always_comb begin
    w_col   = {1'b0, i_Col};
    w_row   = {1'b0, i_Row};
    w_x     = {1'b0, r_ball_x};
    w_y     = {1'b0, r_ball_y};
    w_vball = (w_row >= w_y) && (w_row < (w_y + SIZE_W));
    w_hball = (w_col >= w_x) && (w_col < (w_x + SIZE_W));
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state   <= ST_SERVE;
      r_srv_cnt <= '0;
      r_div_cnt <= '0;
      r_ball_x  <= 10'(X_CTR);
      r_ball_y  <= 10'(Y_CTR);
      r_vball   <= 1'b0;
      r_draw    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_srv_cnt <= w_srv_nxt;
      r_div_cnt <= w_div_nxt;
      r_ball_x  <= w_x_nxt;
      r_ball_y  <= w_y_nxt;
      r_vball   <= w_vball;
      r_draw    <= w_vball && w_hball;
    end
  end

  assign o_Ball_X    = r_ball_x;
  assign o_Ball_Y    = r_ball_y;
  assign o_VBall     = r_vball;
  assign o_Draw_Ball = r_draw;
  assign o_Serving   = (r_state == ST_SERVE);
  assign o_At_Left   = (r_ball_x == 10'd0);
  assign o_At_Right  = (r_ball_x == 10'(X_MAX));
  assign o_At_Top    = (r_ball_y == 10'd0);
  assign o_At_Bottom = (r_ball_y == 10'(Y_MAX));

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: default instance plus a divide-by-3 instance and a
// STEP=3 instance whose odd positions reach the saturating clamps.
module tb_ball_motion;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [9:0] col, row;
  logic       tk0, rc0, h0, v0;
  logic       tk1, h1, v1;
  logic       tk2, h2, v2;
  logic       rc_off;

  logic [9:0] x0, y0, x1, y1, x2, y2;
  logic d0, vb0, l0, r0, t0, b0, s0;
  logic d1, vb1, l1, r1, t1, b1, s1;
  logic d2, vb2, l2, r2, t2, b2, s2;

  int n_checks = 0;
  int n_errors = 0;

  ball_motion u_dut0 (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Frame_Tick(tk0), .i_Recenter(rc0),
    .i_HDir(h0), .i_VDir(v0), .i_Col(col), .i_Row(row),
    .o_Ball_X(x0), .o_Ball_Y(y0), .o_Draw_Ball(d0), .o_VBall(vb0),
    .o_At_Left(l0), .o_At_Right(r0), .o_At_Top(t0), .o_At_Bottom(b0), .o_Serving(s0)
  );

  ball_motion #(.FRAMES_PER_STEP(3), .SERVE_FRAMES(1)) u_dut1 (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Frame_Tick(tk1), .i_Recenter(rc_off),
    .i_HDir(h1), .i_VDir(v1), .i_Col(col), .i_Row(row),
    .o_Ball_X(x1), .o_Ball_Y(y1), .o_Draw_Ball(d1), .o_VBall(vb1),
    .o_At_Left(l1), .o_At_Right(r1), .o_At_Top(t1), .o_At_Bottom(b1), .o_Serving(s1)
  );

  ball_motion #(.STEP(3), .SERVE_FRAMES(1)) u_dut2 (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Frame_Tick(tk2), .i_Recenter(rc_off),
    .i_HDir(h2), .i_VDir(v2), .i_Col(col), .i_Row(row),
    .o_Ball_X(x2), .o_Ball_Y(y2), .o_Draw_Ball(d2), .o_VBall(vb2),
    .o_At_Left(l2), .o_At_Right(r2), .o_At_Top(t2), .o_At_Bottom(b2), .o_Serving(s2)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One tick pulse on the selected instance; outputs are settled at the following negedge.
  task automatic ticks(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      case (sel)
        0: tk0 = 1'b1;
        1: tk1 = 1'b1;
        default: tk2 = 1'b1;
      endcase
      @(negedge clk);
      tk0 = 1'b0; tk1 = 1'b0; tk2 = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; rc_off = 1'b0;
    tk0 = 0; rc0 = 0; h0 = 0; v0 = 0;
    tk1 = 0; h1 = 0; v1 = 0;
    tk2 = 0; h2 = 0; v2 = 0;
    col = 10'd0; row = 10'd0;
    #7;
    chk("rst_x", x0, 316);
    chk("rst_y", y0, 236);
    chk("rst_serving", s0, 1);
    chk("rst_draw", d0, 0);
    chk("rst_vball", vb0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    ticks(0, 59);
    chk("serve59_x", x0, 316);
    chk("serve59_y", y0, 236);
    chk("serve59_serving", s0, 1);
    ticks(0, 1);
    chk("serve60_serving", s0, 0);
    chk("serve60_x", x0, 316);
    chk("serve60_y", y0, 236);
    ticks(0, 1);
    chk("move1_x", x0, 318);
    chk("move1_y", y0, 238);

    // Walk to (100,100): 69 diagonal up-left steps, then 40 left steps with V alternating.
    h0 = 1'b1; v0 = 1'b1;
    ticks(0, 69);
    chk("walk_x", x0, 180);
    chk("walk_y", y0, 100);
    for (int i = 0; i < 40; i++) begin
      v0 = (i % 2 == 1);
      ticks(0, 1);
    end
    chk("at100_x", x0, 100);
    chk("at100_y", y0, 100);

    @(negedge clk);
    rc0 = 1'b1; tk0 = 1'b1;
    @(negedge clk);
    rc0 = 1'b0; tk0 = 1'b0;
    chk("recentre_x", x0, 316);
    chk("recentre_y", y0, 236);
    chk("recentre_serving", s0, 1);
    chk("centre_left", l0, 0);
    chk("centre_right", r0, 0);

    // Recenter inside SERVE restarts the 60-tick count.
    ticks(0, 30);
    @(negedge clk); rc0 = 1'b1;
    @(negedge clk); rc0 = 1'b0;
    ticks(0, 59);
    chk("reserve59_serving", s0, 1);
    ticks(0, 1);
    chk("reserve60_serving", s0, 0);
    chk("reserve60_x", x0, 316);

    // Scan row 240 across the ball; strobes reflect the column presented before the edge.
    row = 10'd240;
    for (int c = 310; c <= 330; c++) begin
      @(negedge clk);
      col = 10'(c);
      @(posedge clk);
      #1;
      chk($sformatf("vball_c%0d", c), vb0, 1);
      chk($sformatf("draw_c%0d", c), d0, (c >= 316 && c <= 323) ? 1 : 0);
    end
    @(negedge clk); row = 10'd243; col = 10'd316;
    @(posedge clk); #1;
    chk("vball_row243", vb0, 1);
    chk("draw_row243", d0, 1);
    @(negedge clk); row = 10'd244;
    @(posedge clk); #1;
    chk("vball_row244", vb0, 0);
    chk("draw_row244", d0, 0);

    // Divide-by-3 instance: X moves only on ticks 3 and 6.
    ticks(1, 1);
    chk("div_serving", s1, 0);
    for (int k = 1; k <= 6; k++) begin
      ticks(1, 1);
      chk($sformatf("div_tick%0d_x", k), x1, 316 + 2 * (k / 3));
    end

    // STEP=3 instance: odd positions exercise the saturating clamps.
    ticks(2, 1);
    h2 = 1'b1; v2 = 1'b1;
    ticks(2, 78);
    chk("s3_up78_y", y2, 2);
    chk("s3_up78_x", x2, 82);
    chk("s3_up78_top", t2, 0);
    ticks(2, 1);
    chk("s3_up79_y", y2, 0);
    chk("s3_up79_top", t2, 1);
    chk("s3_up79_x", x2, 79);
    ticks(2, 26);
    chk("s3_x1", x2, 1);
    chk("s3_x1_left", l2, 0);
    ticks(2, 1);
    chk("s3_x0", x2, 0);
    chk("s3_x0_left", l2, 1);
    ticks(2, 1);
    chk("s3_hold_x", x2, 0);
    chk("s3_hold_y", y2, 0);
    h2 = 1'b0; v2 = 1'b0;
    ticks(2, 157);
    chk("s3_dn157_y", y2, 471);
    chk("s3_dn157_bottom", b2, 0);
    ticks(2, 1);
    chk("s3_dn158_y", y2, 472);
    chk("s3_dn158_bottom", b2, 1);
    chk("s3_dn158_x", x2, 474);
    ticks(2, 52);
    chk("s3_x630", x2, 630);
    chk("s3_x630_right", r2, 0);
    ticks(2, 1);
    chk("s3_x632", x2, 632);
    chk("s3_x632_right", r2, 1);
    ticks(2, 1);
    chk("s3_hold_right_x", x2, 632);
    chk("s3_hold_bottom_y", y2, 472);

    // Asynchronous reset away from any clock edge.
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_x", x2, 316);
    chk("async_rst_y", y2, 236);
    chk("async_rst_serving", s2, 1);
    chk("async_rst_div_x", x1, 316);
    #10;
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
